// File: rtl/prime_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prime_pkg
//  Description : Shared widths, FSM state encoding and range clamp helper
//                for the prime scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package prime_pkg;

    localparam int N_MAX = 999999;
    localparam int AW    = 20;
    localparam int CW    = 17;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EVAL  = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int unsigned clamp(input int unsigned v,
                                          input int unsigned lo_b,
                                          input int unsigned hi_b);
        if (v < lo_b)
            return lo_b;
        else if (v > hi_b)
            return hi_b;
        else
            return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prime_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : prime_scanner
//  Description : Walks the sieve flag RAM over [lo, hi] and streams every
//                prime found over a valid/ready port, counting them.
//  Revision    : 1.0 - initial release
// ============================================================================
module prime_scanner #(
    parameter int N  = prime_pkg::N_MAX,
    parameter int AW = prime_pkg::AW,
    parameter int CW = prime_pkg::CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] lo,
    input  logic [AW-1:0] hi,
    output logic [AW-1:0] ram_addr,
    input  logic          ram_rdata,
    output logic          prime_valid,
    input  logic          prime_ready,
    output logic [AW-1:0] prime_data,
    output logic [CW-1:0] prime_cnt,
    output logic          busy,
    output logic          done
);
    import prime_pkg::*;

    state_t        state;
    logic [AW-1:0] cur;
    logic [AW-1:0] hi_c;
    logic [AW-1:0] lo_n;
    logic [AW-1:0] hi_n;
    logic [AW-1:0] cur_next;
    logic          at_end;

    // Lower bound of 2 keeps 0 and 1 out of the stream regardless of RAM flags.
    assign lo_n     = AW'(clamp(32'(lo), 32'd2, 32'hFFFF_FFFF));
    assign hi_n     = AW'(clamp(32'(hi), 32'd0, 32'(N)));
    assign cur_next = cur + AW'(1);
    assign at_end   = (cur == hi_c);

    // ram_addr is loaded on entry to FETCH so the RAM captures it during FETCH
    // and the flag for cur is present on ram_rdata in EVAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cur         <= '0;
            hi_c        <= '0;
            ram_addr    <= '0;
            prime_valid <= 1'b0;
            prime_data  <= '0;
            prime_cnt   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        hi_c      <= hi_n;
                        prime_cnt <= '0;
                        if (lo_n > hi_n) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cur      <= lo_n;
                            ram_addr <= lo_n;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            state    <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    state <= EVAL;
                end
                EVAL: begin
                    if (!ram_rdata) begin
                        prime_data  <= cur;
                        prime_valid <= 1'b1;
                        state       <= OUT;
                    end else if (at_end) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cur      <= cur_next;
                        ram_addr <= cur_next;
                        state    <= FETCH;
                    end
                end
                OUT: begin
                    if (prime_ready) begin
                        prime_valid <= 1'b0;
                        if (prime_cnt != {CW{1'b1}})
                            prime_cnt <= prime_cnt + CW'(1);
                        if (at_end) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cur      <= cur_next;
                            ram_addr <= cur_next;
                            state    <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prime_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prime_scanner
//  Description : Directed self-checking bench for prime_scanner with a
//                1-cycle-latency sieve RAM and a trial-division prime model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prime_scanner;

    localparam int TB_N  = 9999;
    localparam int AW    = 20;
    localparam int CW    = 17;
    localparam int BOUND = 50000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    logic [AW-1:0] ram_addr;
    logic          ram_rdata = 1'b1;
    logic          prime_valid;
    logic          prime_ready;
    logic [AW-1:0] prime_data;
    logic [CW-1:0] prime_cnt;
    logic          busy;
    logic          done;

    int vectors     = 0;
    int miscompares = 0;

    logic flag_mem [0:TB_N];
    int   exp_q[$];
    int   hs_count;
    int   last_seen;
    int   ready_mode;
    logic          prev_stall;
    logic [AW-1:0] prev_data;

    prime_scanner #(.N(TB_N), .AW(AW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .lo         (lo),
        .hi         (hi),
        .ram_addr   (ram_addr),
        .ram_rdata  (ram_rdata),
        .prime_valid(prime_valid),
        .prime_ready(prime_ready),
        .prime_data (prime_data),
        .prime_cnt  (prime_cnt),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Registered-address flag RAM
    always @(posedge clk)
        ram_rdata <= (int'(ram_addr) <= TB_N) ? flag_mem[ram_addr] : 1'b1;

    function automatic bit is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++)
            if (v % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Handshake-level compare against the model queue
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                vectors++;
                if (!prime_valid || prime_data != prev_data) begin
                    miscompares++;
                    $display("FAIL stall_hold: valid=%0b data=%0d, expected valid=1 data=%0d",
                             prime_valid, prime_data, prev_data);
                end
            end
            if (prime_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_prime: got %0d, expected no prime", prime_data);
                end else if (prime_ready) begin
                    int e;
                    e = exp_q.pop_front();
                    vectors++;
                    if (int'(prime_data) != e) begin
                        miscompares++;
                        $display("FAIL prime_data: got %0d, expected %0d", prime_data, e);
                    end
                    vectors++;
                    if (int'(prime_cnt) != hs_count) begin
                        miscompares++;
                        $display("FAIL prime_cnt_running: got %0d, expected %0d", prime_cnt, hs_count);
                    end
                    hs_count++;
                    last_seen = int'(prime_data);
                end
            end
            prev_stall = prime_valid && !prime_ready;
            prev_data  = prime_data;
        end
    end

    // Consumer ready: 0 = always, 1 = random, 2 = held low
    initial begin
        prime_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       prime_ready = 1'b1;
                1:       prime_ready = 1'($urandom_range(0, 1));
                default: prime_ready = 1'b0;
            endcase
        end
    end

    task automatic load_model(input int l, input int h);
        int lc, hc;
        exp_q.delete();
        hs_count  = 0;
        last_seen = -1;
        lc = (l < 2) ? 2 : l;
        hc = (h > TB_N) ? TB_N : h;
        for (int v = lc; v <= hc; v++)
            if (is_prime(v)) exp_q.push_back(v);
    endtask

    task automatic pulse_start(input int l, input int h);
        @(posedge clk); #1;
        lo = AW'(l); hi = AW'(h); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_scan(input string tag, input int l, input int h, input int rmode,
                            input bit inject, input int lit_cnt, input int lit_last);
        int lc, hc, n_exp, cyc;
        lc = (l < 2) ? 2 : l;
        hc = (h > TB_N) ? TB_N : h;
        load_model(l, h);
        n_exp = exp_q.size();
        ready_mode = rmode;
        pulse_start(l, h);
        if (lc > hc) begin
            check({tag, "_done_at_1"}, done, 1);
            check({tag, "_busy_at_1"}, busy, 0);
        end else begin
            check({tag, "_first_addr"}, ram_addr, lc);
            check({tag, "_busy_at_1"}, busy, 1);
            check({tag, "_valid_at_1"}, prime_valid, 0);
        end
        cyc = 0;
        while (!done && cyc < BOUND) begin
            if (inject && cyc == 6) begin
                lo = AW'(500); hi = AW'(600); start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (cyc >= BOUND) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got no done after %0d cycles, expected done", tag, cyc);
        end
        check({tag, "_all_primes_seen"}, exp_q.size(), 0);
        check({tag, "_cnt_model"}, prime_cnt, n_exp);
        check({tag, "_cnt_literal"}, prime_cnt, lit_cnt);
        check({tag, "_last_literal"}, last_seen, lit_last);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid_idle"}, prime_valid, 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; lo = '0; hi = '0; ready_mode = 0;
        for (int i = 0; i <= TB_N; i++) flag_mem[i] = 1'b0;
        for (int i = 2; i * i <= TB_N; i++)
            if (!flag_mem[i])
                for (int j = i * i; j <= TB_N; j += i) flag_mem[j] = 1'b1;
        // 0 and 1 left flagged as candidates: the scanner must still skip them
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("reset_addr", ram_addr, 0);
        check("reset_valid", prime_valid, 0);
        check("reset_data", prime_data, 0);
        check("reset_cnt", prime_cnt, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;

        run_scan("r2_30",   2,  30, 0, 1'b0, 10, 29);
        run_scan("r0_1",    0,   1, 0, 1'b0,  0, -1);
        run_scan("r0_10",   0,  10, 0, 1'b0,  4,  7);
        run_scan("r97",    97,  97, 0, 1'b0,  1, 97);
        run_scan("r91",    91,  91, 0, 1'b0,  0, -1);
        run_scan("bp2_30",  2,  30, 1, 1'b0, 10, 29);
        run_scan("inj2_30", 2,  30, 0, 1'b1, 10, 29);
        run_scan("full",    0, 1048575, 0, 1'b0, 1229, 9973);

        // Abort while a prime is being offered
        load_model(2, 30);
        ready_mode = 2;
        pulse_start(2, 30);
        cyc = 0;
        while (!prime_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("out_reached", prime_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_addr", ram_addr, 0);
        check("mid_rst_valid", prime_valid, 0);
        check("mid_rst_data", prime_data, 0);
        check("mid_rst_cnt", prime_cnt, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        exp_q.delete();
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_scan("after_rst", 2, 30, 0, 1'b0, 10, 29);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
